// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel (AR/R) between the instruction-fetch and data-load ports.
// Optional AXI_RD_RR_EN selects round-robin arbitration instead of fixed data-over-inst priority.
module axi_rd_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [1:0]        inst_size,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [1:0]        data_size,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic [7:0]        arlen,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    AR_WAIT = 1'b1
  } state_t;

  state_t            state_r, state_nx_s;
  logic              arvalid_r;
  logic [ADDR_W-1:0] araddr_r;
  logic [3:0]        arid_r;
  logic [2:0]        arsize_r;
  logic              rready_r;
  logic [CNT_W-1:0]  cnt_inst_r, cnt_data_r;
  logic              inst_elig_s, data_elig_s;
  logic              grant_inst_s, grant_data_s;
  logic              unused_s;
`ifdef AXI_RD_RR_EN
  logic              last_data_r;
`endif

  // Outstanding count update: +1 on issue, -1 on return, both together cancel.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    case ({inc, dec})
      2'b10:   res = cnt + CNT_ONE;
      2'b01:   res = cnt - CNT_ONE;
      default: res = cnt;
    endcase
    return res;
  endfunction

  assign inst_elig_s = inst_req & (cnt_inst_r < CNT_MAX);
  assign data_elig_s = data_req & (cnt_data_r < CNT_MAX);

  // Only the low RID bit routes responses; upper bits are ignored.
  assign unused_s = ^rid[3:1];

  assign inst_addr_ok = arvalid_r & arready & (arid_r == 4'd0);
  assign data_addr_ok = arvalid_r & arready & (arid_r == 4'd1);
  assign inst_data_ok = rvalid & rready_r & ~rid[0] & (cnt_inst_r != CNT_ZERO);
  assign data_data_ok = rvalid & rready_r &  rid[0] & (cnt_data_r != CNT_ZERO);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arvalid = arvalid_r;
  assign araddr  = araddr_r;
  assign arid    = arid_r;
  assign arsize  = arsize_r;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign rready  = rready_r;

  // Arbitration and next-state: grants are only made from IDLE.
  always_comb begin
    grant_inst_s = 1'b0;
    grant_data_s = 1'b0;
    state_nx_s   = state_r;
    case (state_r)
      IDLE: begin
`ifdef AXI_RD_RR_EN
        if (inst_elig_s && data_elig_s) begin
          grant_data_s = ~last_data_r;
          grant_inst_s =  last_data_r;
        end else begin
          grant_data_s = data_elig_s;
          grant_inst_s = inst_elig_s;
        end
`else
        grant_data_s = data_elig_s;
        grant_inst_s = inst_elig_s & ~data_elig_s;
`endif
        if (grant_inst_s || grant_data_s) begin
          state_nx_s = AR_WAIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      AR_WAIT: begin
        if (arready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = AR_WAIT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // AR channel registers: loaded on grant, held stable until the handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_r <= 1'b0;
      araddr_r  <= '0;
      arid_r    <= 4'd0;
      arsize_r  <= 3'd0;
    end else if (grant_inst_s || grant_data_s) begin
      arvalid_r <= 1'b1;
      araddr_r  <= grant_data_s ? data_addr : inst_addr;
      arid_r    <= grant_data_s ? 4'd1 : 4'd0;
      arsize_r  <= {1'b0, (grant_data_s ? data_size : inst_size)};
    end else if ((state_r == AR_WAIT) && arready) begin
      arvalid_r <= 1'b0;
    end
  end

  // R is always accepted once out of reset; unowned beats are silently dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rready_r <= 1'b0;
    end else begin
      rready_r <= 1'b1;
    end
  end

  // Per-requester outstanding counters; issue blocking keeps them from passing MAX_OUTST.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_inst_r <= CNT_ZERO;
      cnt_data_r <= CNT_ZERO;
    end else begin
      cnt_inst_r <= next_cnt(cnt_inst_r, inst_addr_ok, inst_data_ok);
      cnt_data_r <= next_cnt(cnt_data_r, data_addr_ok, data_data_ok);
    end
  end

`ifdef AXI_RD_RR_EN
  // Remember who won last so a tie goes to the other requester.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_data_r <= 1'b0;
    end else if (grant_inst_s || grant_data_s) begin
      last_data_r <= grant_data_s;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (default fixed-priority build).
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr;
  logic [1:0]  inst_size, data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid, arready, rvalid, rready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0; inst_addr = 32'd0; data_addr = 32'd0;
    inst_size = 2'd0; data_size = 2'd0; arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
    tick(); tick();
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid got=%0h exp=0", arvalid); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rst_rready got=%0h exp=0", rready); end
    checks++; if (araddr !== 32'd0) begin failures++; $display("FAIL rst_araddr got=%0h exp=0", araddr); end
    checks++; if (arid !== 4'd0) begin failures++; $display("FAIL rst_arid got=%0h exp=0", arid); end
    checks++; if (arsize !== 3'd0) begin failures++; $display("FAIL rst_arsize got=%0h exp=0", arsize); end
    resetn = 1'b1;
    #1;
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rst_rready_pre_edge got=%0h exp=0", rready); end
    tick();
    checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rst_rready_exit got=%0h exp=1", rready); end
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_idle_arvalid got=%0h exp=0", arvalid); end
  endtask

  task automatic test_single_inst();
    inst_addr = 32'h1c000000; inst_size = 2'd2; inst_req = 1'b1; arready = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL single_cycle1_arvalid got=%0h exp=0", arvalid); end
    tick();
    checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL single_arvalid got=%0h exp=1", arvalid); end
    checks++; if (arid !== 4'd0) begin failures++; $display("FAIL single_arid got=%0h exp=0", arid); end
    checks++; if (araddr !== 32'h1c000000) begin failures++; $display("FAIL single_araddr got=%0h exp=1c000000", araddr); end
    checks++; if (arsize !== 3'b010) begin failures++; $display("FAIL single_arsize got=%0h exp=2", arsize); end
    checks++; if (arlen !== 8'd0) begin failures++; $display("FAIL single_arlen got=%0h exp=0", arlen); end
    checks++; if (arburst !== 2'b01) begin failures++; $display("FAIL single_arburst got=%0h exp=1", arburst); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("FAIL single_addr_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    tick();
    inst_req = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL single_arvalid_drop got=%0h exp=0", arvalid); end
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h02800000;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL single_data_ok got=%b exp=10", {inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'h02800000) begin failures++; $display("FAIL single_rdata got=%0h exp=2800000", inst_rdata); end
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_priority_out_of_order();
    inst_addr = 32'h1c000100; inst_size = 2'd2; data_addr = 32'h80001000; data_size = 2'd1;
    inst_req = 1'b1; data_req = 1'b1; arready = 1'b1;
    tick();
    checks++; if (arid !== 4'd1) begin failures++; $display("FAIL prio_first_arid got=%0h exp=1", arid); end
    checks++; if (araddr !== 32'h80001000) begin failures++; $display("FAIL prio_first_araddr got=%0h exp=80001000", araddr); end
    checks++; if (arsize !== 3'b001) begin failures++; $display("FAIL prio_first_arsize got=%0h exp=1", arsize); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin failures++; $display("FAIL prio_first_addr_ok got=%b exp=01", {inst_addr_ok, data_addr_ok}); end
    tick();
    data_req = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL prio_gap_arvalid got=%0h exp=0", arvalid); end
    tick();
    checks++; if ({arvalid, arid} !== 5'b1_0000) begin failures++; $display("FAIL prio_second_arid got=%0h/%0h exp=1/0", arvalid, arid); end
    checks++; if (araddr !== 32'h1c000100) begin failures++; $display("FAIL prio_second_araddr got=%0h exp=1c000100", araddr); end
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL prio_second_addr_ok got=%0h exp=1", inst_addr_ok); end
    tick();
    inst_req = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hdddd0001;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL ooo_data_ok got=%b exp=01", {inst_data_ok, data_data_ok}); end
    checks++; if (data_rdata !== 32'hdddd0001) begin failures++; $display("FAIL ooo_data_rdata got=%0h exp=dddd0001", data_rdata); end
    tick();
    rid = 4'd0; rdata = 32'h11110000;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL ooo_inst_ok got=%b exp=10", {inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'h11110000) begin failures++; $display("FAIL ooo_inst_rdata got=%0h exp=11110000", inst_rdata); end
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_ar_stall();
    arready = 1'b0; inst_addr = 32'h1c000200; inst_size = 2'd2; inst_req = 1'b1; data_size = 2'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      data_req = ((i % 2) == 0);
      data_addr = 32'h80002000 + 32'(i * 4);
      #1;
      checks++; if ({arvalid, arid} !== 5'b1_0000) begin failures++; $display("FAIL stall_arvalid_arid[%0d] got=%0h/%0h exp=1/0", i, arvalid, arid); end
      checks++; if (araddr !== 32'h1c000200) begin failures++; $display("FAIL stall_araddr[%0d] got=%0h exp=1c000200", i, araddr); end
      checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL stall_addr_ok[%0d] got=%b exp=00", i, {inst_addr_ok, data_addr_ok}); end
      tick();
    end
    data_req = 1'b0; arready = 1'b1;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("FAIL stall_release_addr_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    tick();
    inst_req = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h22220000;
    #1;
    checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL stall_drain_ok got=%0h exp=1", inst_data_ok); end
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_outstanding_limit();
    arready = 1'b1; inst_addr = 32'h1c000300; inst_size = 2'd2; inst_req = 1'b1;
    tick();
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL lim_issue1 got=%0h exp=1", inst_addr_ok); end
    tick();
    tick();
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL lim_issue2 got=%0h exp=1", inst_addr_ok); end
    tick();
    tick();
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL lim_blocked got=%0h exp=0", arvalid); end
    data_req = 1'b1; data_addr = 32'h80003000; data_size = 2'd2;
    tick();
    checks++; if ({arvalid, arid, data_addr_ok} !== 6'b1_0001_1) begin failures++; $display("FAIL lim_data_issue got=%0h/%0h/%0h exp=1/1/1", arvalid, arid, data_addr_ok); end
    tick();
    data_req = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h33330000;
    #1;
    checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL lim_ret_ok got=%0h exp=1", inst_data_ok); end
    tick();
    rvalid = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL lim_unblock_gap got=%0h exp=0", arvalid); end
    tick();
    checks++; if ({arvalid, arid, inst_addr_ok} !== 6'b1_0000_1) begin failures++; $display("FAIL lim_unblock got=%0h/%0h/%0h exp=1/0/1", arvalid, arid, inst_addr_ok); end
    tick();
    inst_req = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h44440001;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL lim_drain_data got=%b exp=01", {inst_data_ok, data_data_ok}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      rid = 4'd0; rdata = 32'h55550000 + 32'(i);
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL lim_drain_inst[%0d] got=%b exp=10", i, {inst_data_ok, data_data_ok}); end
    end
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_unexpected_r();
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hbad00001;
    #1;
    checks++; if ({inst_data_ok, data_data_ok, rready} !== 3'b001) begin failures++; $display("FAIL unexp_rid1 got=%b exp=001", {inst_data_ok, data_data_ok, rready}); end
    tick();
    rid = 4'd0; rdata = 32'hbad00000;
    #1;
    checks++; if ({inst_data_ok, data_data_ok, rready} !== 3'b001) begin failures++; $display("FAIL unexp_rid0 got=%b exp=001", {inst_data_ok, data_data_ok, rready}); end
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_reset_midop();
    arready = 1'b1; inst_addr = 32'h1c000400; inst_size = 2'd2; inst_req = 1'b1;
    tick();
    tick();
    arready = 1'b0;
    tick();
    checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL midrst_pre_arvalid got=%0h exp=1", arvalid); end
    resetn = 1'b0;
    #1;
    checks++; if ({arvalid, rready} !== 2'b00) begin failures++; $display("FAIL midrst_async got=%b exp=00", {arvalid, rready}); end
    checks++; if (araddr !== 32'd0) begin failures++; $display("FAIL midrst_araddr got=%0h exp=0", araddr); end
    inst_req = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    checks++; if (rready !== 1'b1) begin failures++; $display("FAIL midrst_rready got=%0h exp=1", rready); end
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h66660000;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL midrst_stray got=%b exp=00", {inst_data_ok, data_data_ok}); end
    tick();
    rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_inst();
    test_priority_out_of_order();
    test_ar_stall();
    test_outstanding_limit();
    test_unexpected_r();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
